// File: rtl/obj_linelatch_sequencer.sv
// Object line-latch control sequencer.
// Turns one sprite-line draw job into pixel select / latch strobes for the
// line latch, fetches tile rows over a REQ/ACK handshake, and produces
// line-buffer addresses and write enables aligned with the DA/DB pixel pairs.
module obj_linelatch_sequencer #(
    parameter int PIPE_DLY = 4
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_RST,
    input  logic       i_EMU_CLK6MPCEN_n,
    input  logic       i_START,
    input  logic [8:0] i_XPOS,
    input  logic [7:0] i_WIDTH,
    input  logic       i_HFLIP,
    output logic       o_BUSY,
    output logic       o_GFXREQ,
    output logic [4:0] o_TILEIDX,
    input  logic       i_GFXACK,
    output logic       o_TILELINELATCH_n,
    output logic       o_COLORLATCH_n,
    output logic       o_WRTIME2,
    output logic       o_PIXELLATCH_WAIT_n,
    output logic [2:0] o_PIXELSEL,
    output logic       o_XPOS_D0,
    output logic [7:0] o_LBADDR_A,
    output logic [7:0] o_LBADDR_B,
    output logic       o_LBWE_A_n,
    output logic       o_LBWE_B_n
);

    localparam int DW = $clog2(PIPE_DLY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_q;
    logic [8:0]      xpos_q;
    logic [7:0]      last_q;        // index of the final pixel (N-1)
    logic            hflip_q;
    logic [7:0]      pix_q;         // relative pixel index of the next slot
    logic            waitslot_q;    // next EMIT slot is the trailing wait slot
    logic [DW-1:0]   drain_q;
    logic            busy_q;
    logic            gfxreq_q;
    logic [4:0]      tileidx_q;
    logic [4:0]      nexttile_q;
    logic            colorlatch_n_q;
    logic [2:0]      pixelsel_q;
    logic [3:0]      tln_q;         // tile-line latch strobe, active low, by slot age
    logic [3:0]      rq_q;          // pending next-tile request, by slot age
    logic [1:0]      waitn_q;
    logic [2:0]      wr_q;
    logic [PIPE_DLY:0]      wean_q;
    logic [PIPE_DLY:0]      webn_q;
    logic [PIPE_DLY:0][7:0] adra_q;
    logic [PIPE_DLY:0][7:0] adrb_q;

    // Slot-local values feeding the head of each delay pipeline.
    logic       en_s;
    logic [8:0] col_s;
    logic [2:0] sel_s;
    logic       tile_start_s;
    logic       more_tiles_s;
    logic [4:0] next_tile_s;
    logic       waitn_d;
    logic       wr_d;
    logic       wea_d;
    logic       web_d;
    logic [7:0] adra_d;
    logic [7:0] adrb_d;

    // Decode the current slot: column, select, tile bookkeeping and write data.
    always_comb begin
        en_s         = ~i_EMU_CLK6MPCEN_n;
        col_s        = xpos_q + {1'b0, pix_q};
        sel_s        = hflip_q ? ~pix_q[2:0] : pix_q[2:0];
        more_tiles_s = (pix_q[7:3] != last_q[7:3]);
        next_tile_s  = hflip_q ? (last_q[7:3] - pix_q[7:3] - 5'd1) : (pix_q[7:3] + 5'd1);
        tile_start_s = 1'b0;
        waitn_d      = 1'b1;
        wr_d         = (state_q == ST_FETCH);
        wea_d        = 1'b0;
        web_d        = 1'b0;
        adra_d       = 8'd0;
        adrb_d       = 8'd0;
        if (state_q == ST_EMIT) begin
            if (waitslot_q) begin
                // Lone final pixel: only the bank owning its column is written.
                waitn_d = 1'b0;
                wr_d    = 1'b1;
                wea_d   = ~col_s[0];
                web_d   = col_s[0];
                adra_d  = col_s[8:1];
                adrb_d  = col_s[8:1];
            end else begin
                tile_start_s = (pix_q[2:0] == 3'd0);
                wr_d         = pix_q[0];
                if (pix_q[0]) begin
                    // Pair of columns col-1 and col: the even one always sits at
                    // word col[8:1]; the odd one is one word lower when col is even.
                    wea_d  = 1'b1;
                    web_d  = 1'b1;
                    adra_d = col_s[8:1];
                    adrb_d = col_s[0] ? col_s[8:1] : (col_s[8:1] - 8'd1);
                end else begin
                    wea_d  = 1'b0;
                    web_d  = 1'b0;
                end
            end
        end else begin
            tile_start_s = 1'b0;
        end
    end

    // Job state machine, strobe generation and output-alignment pipelines.
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_RST) begin
            state_q        <= ST_IDLE;
            xpos_q         <= 9'd0;
            last_q         <= 8'd0;
            hflip_q        <= 1'b0;
            pix_q          <= 8'd0;
            waitslot_q     <= 1'b0;
            drain_q        <= '0;
            busy_q         <= 1'b0;
            gfxreq_q       <= 1'b0;
            tileidx_q      <= 5'd0;
            nexttile_q     <= 5'd0;
            colorlatch_n_q <= 1'b1;
            pixelsel_q     <= 3'd0;
            tln_q          <= 4'b1111;
            rq_q           <= 4'b0000;
            waitn_q        <= 2'b11;
            wr_q           <= 3'b000;
            wean_q         <= '1;
            webn_q         <= '1;
            adra_q         <= '0;
            adrb_q         <= '0;
        end else if (en_s) begin
            colorlatch_n_q <= 1'b1;
            gfxreq_q       <= 1'b0;
            tln_q          <= {tln_q[2:0], ~tile_start_s};
            rq_q           <= {rq_q[2:0], tile_start_s & more_tiles_s};
            waitn_q        <= {waitn_q[0], waitn_d};
            wr_q           <= {wr_q[1:0], wr_d};
            wean_q         <= {wean_q[PIPE_DLY-1:0], ~wea_d};
            webn_q         <= {webn_q[PIPE_DLY-1:0], ~web_d};
            adra_q         <= {adra_q[PIPE_DLY-1:0], adra_d};
            adrb_q         <= {adrb_q[PIPE_DLY-1:0], adrb_d};
            if (tile_start_s) begin
                nexttile_q <= next_tile_s;
            end
            if (rq_q[3]) begin
                gfxreq_q  <= 1'b1;
                tileidx_q <= nexttile_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_START) begin
                        xpos_q         <= i_XPOS;
                        last_q         <= i_WIDTH;
                        hflip_q        <= i_HFLIP;
                        pix_q          <= 8'd0;
                        waitslot_q     <= 1'b0;
                        busy_q         <= 1'b1;
                        colorlatch_n_q <= 1'b0;
                        gfxreq_q       <= 1'b1;
                        tileidx_q      <= i_HFLIP ? i_WIDTH[7:3] : 5'd0;
                        state_q        <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (i_GFXACK) begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (waitslot_q) begin
                        waitslot_q <= 1'b0;
                        drain_q    <= '0;
                        state_q    <= ST_DRAIN;
                    end else begin
                        pixelsel_q <= sel_s;
                        if (pix_q == last_q) begin
                            if (!pix_q[0]) begin
                                waitslot_q <= 1'b1;
                            end else begin
                                drain_q <= '0;
                                state_q <= ST_DRAIN;
                            end
                        end else begin
                            pix_q <= pix_q + 8'd1;
                            if (pix_q[2:0] == 3'd7) begin
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DW'(PIPE_DLY - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_BUSY              = busy_q;
    assign o_GFXREQ            = gfxreq_q;
    assign o_TILEIDX           = tileidx_q;
    assign o_TILELINELATCH_n   = tln_q[3];
    assign o_COLORLATCH_n      = colorlatch_n_q;
    assign o_WRTIME2           = wr_q[2];
    assign o_PIXELLATCH_WAIT_n = waitn_q[1];
    assign o_PIXELSEL          = pixelsel_q;
    assign o_XPOS_D0           = xpos_q[0];
    assign o_LBADDR_A          = adra_q[PIPE_DLY];
    assign o_LBADDR_B          = adrb_q[PIPE_DLY];
    assign o_LBWE_A_n          = wean_q[PIPE_DLY];
    assign o_LBWE_B_n          = webn_q[PIPE_DLY];

endmodule

// File: tb/tb_obj_linelatch_sequencer.sv
// Directed bench for obj_linelatch_sequencer. Each job is logged cycle by
// cycle (cycle 1 = first cycle after the START edge) and checked against
// hand-computed cycle positions.
module tb_obj_linelatch_sequencer;
    localparam int LOGN = 128;

    logic       clk = 1'b0;
    logic       rst, en_n, start, hflip, ack;
    logic [8:0] xpos;
    logic [7:0] width;
    logic       busy, req, tln, coln, wr2, waitn, xd0, wean, webn;
    logic [4:0] tidx;
    logic [2:0] sel;
    logic [7:0] adra, adrb;

    always #5 clk = ~clk;

    obj_linelatch_sequencer #(.PIPE_DLY(4)) dut (
        .i_EMU_MCLK(clk), .i_RST(rst), .i_EMU_CLK6MPCEN_n(en_n), .i_START(start),
        .i_XPOS(xpos), .i_WIDTH(width), .i_HFLIP(hflip),
        .o_BUSY(busy), .o_GFXREQ(req), .o_TILEIDX(tidx), .i_GFXACK(ack),
        .o_TILELINELATCH_n(tln), .o_COLORLATCH_n(coln), .o_WRTIME2(wr2),
        .o_PIXELLATCH_WAIT_n(waitn), .o_PIXELSEL(sel), .o_XPOS_D0(xd0),
        .o_LBADDR_A(adra), .o_LBADDR_B(adrb), .o_LBWE_A_n(wean), .o_LBWE_B_n(webn)
    );

    int npass = 0;
    int ntot  = 0;

    logic [2:0] lg_sel  [0:LOGN-1];
    logic [4:0] lg_tidx [0:LOGN-1];
    logic [7:0] lg_adra [0:LOGN-1];
    logic [7:0] lg_adrb [0:LOGN-1];
    logic       lg_wea  [0:LOGN-1];
    logic       lg_web  [0:LOGN-1];
    logic       lg_busy [0:LOGN-1];
    logic       lg_req  [0:LOGN-1];
    logic       lg_tln  [0:LOGN-1];
    logic       lg_col  [0:LOGN-1];
    logic       lg_wr   [0:LOGN-1];
    logic       lg_wait [0:LOGN-1];
    logic       lg_xd0  [0:LOGN-1];
    int n_wea, n_web, n_tl, n_col, n_req, n_wait, last_k;

    // Runs one job: START with the given fields, ACK ack_dly cycles after each
    // REQ, optional reset at rst_cyc and a spurious START at restart_cyc.
    task automatic run_job(input logic [8:0] xp, input logic [7:0] wd, input logic hf,
                           input int ack_dly, input int rst_cyc, input int restart_cyc);
        int ack_at;
        int done_at;
        for (int i = 0; i < LOGN; i++) begin
            lg_sel[i] = 3'd0; lg_tidx[i] = 5'd0; lg_adra[i] = 8'd0; lg_adrb[i] = 8'd0;
            lg_wea[i] = 1'b1; lg_web[i] = 1'b1; lg_busy[i] = 1'b0; lg_req[i] = 1'b0;
            lg_tln[i] = 1'b1; lg_col[i] = 1'b1; lg_wr[i] = 1'b0; lg_wait[i] = 1'b1;
            lg_xd0[i] = 1'b0;
        end
        n_wea = 0; n_web = 0; n_tl = 0; n_col = 0; n_req = 0; n_wait = 0;
        ack_at = -1; done_at = -1; last_k = 0;
        @(negedge clk);
        xpos = xp; width = wd; hflip = hf; start = 1'b1;
        for (int k = 1; k < LOGN; k++) begin
            @(negedge clk);
            start = 1'b0; ack = 1'b0; rst = 1'b0;
            lg_sel[k] = sel; lg_tidx[k] = tidx; lg_adra[k] = adra; lg_adrb[k] = adrb;
            lg_wea[k] = wean; lg_web[k] = webn; lg_busy[k] = busy; lg_req[k] = req;
            lg_tln[k] = tln; lg_col[k] = coln; lg_wr[k] = wr2; lg_wait[k] = waitn;
            lg_xd0[k] = xd0;
            if (!wean) n_wea++;
            if (!webn) n_web++;
            if (!tln) n_tl++;
            if (!coln) n_col++;
            if (req) n_req++;
            if (!waitn) n_wait++;
            last_k = k;
            if (req) ack_at = k + ack_dly;
            if (k == ack_at) ack = 1'b1;
            if (k == rst_cyc) rst = 1'b1;
            if (k == restart_cyc) begin
                start = 1'b1;
                xpos  = 9'h100;
            end
            if (!busy && done_at < 0) done_at = k;
            if (done_at >= 0 && k >= done_at + 8) break;
        end
        ntot++;
        if (done_at < 0) $display("FAIL job_timeout: busy never dropped within %0d cycles", LOGN);
        else npass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_n = 1'b0; start = 1'b0; ack = 1'b0; hflip = 1'b0;
        xpos = 9'd0; width = 8'd0;
        repeat (3) @(negedge clk);
        ntot++;
        if ({busy, req, wr2, tln, coln, waitn, wean, webn} !== 8'b0001_1111)
            $display("FAIL reset_ctrl: got %b want 00011111", {busy, req, wr2, tln, coln, waitn, wean, webn});
        else npass++;
        ntot++;
        if ({sel, tidx, adra, adrb, xd0} !== 25'd0)
            $display("FAIL reset_data: got sel=%0d tidx=%0d a=%h b=%h xd0=%b want all 0", sel, tidx, adra, adrb, xd0);
        else npass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_enable();
        en_n = 1'b1; start = 1'b1; xpos = 9'd5; width = 8'd3;
        repeat (3) @(negedge clk);
        ntot++;
        if ({busy, req, coln} !== 3'b001)
            $display("FAIL enable_gate: busy/req/col_n got %b want 001", {busy, req, coln});
        else npass++;
        start = 1'b0; en_n = 1'b0;
        repeat (2) @(negedge clk);
        ntot++;
        if (busy !== 1'b0) $display("FAIL enable_idle: busy got %b want 0", busy);
        else npass++;
    endtask

    task automatic test_basic();
        run_job(9'h010, 8'd7, 1'b0, 2, -1, 6);
        ntot++;
        if (lg_col[1] !== 1'b0 || n_col !== 1 || lg_req[1] !== 1'b1 || lg_tidx[1] !== 5'd0)
            $display("FAIL basic_start: col_n=%b ncol=%0d req=%b tidx=%0d want 0/1/1/0", lg_col[1], n_col, lg_req[1], lg_tidx[1]);
        else npass++;
        for (int p = 0; p < 8; p++) begin
            ntot++;
            if (lg_sel[5 + p] !== 3'(p)) $display("FAIL basic_sel%0d: got %0d want %0d", p, lg_sel[5 + p], p);
            else npass++;
            ntot++;
            if (lg_wr[7 + p] !== 1'(p)) $display("FAIL basic_wrtime2_%0d: got %b want %0d", p, lg_wr[7 + p], p % 2);
            else npass++;
        end
        for (int i = 0; i < 4; i++) begin
            ntot++;
            if (lg_wea[10 + 2 * i] !== 1'b0 || lg_web[10 + 2 * i] !== 1'b0 ||
                lg_adra[10 + 2 * i] !== 8'(8 + i) || lg_adrb[10 + 2 * i] !== 8'(8 + i))
                $display("FAIL basic_pair%0d: we=%b%b a=%h b=%h want 00 %h %h", i,
                         lg_wea[10 + 2 * i], lg_web[10 + 2 * i], lg_adra[10 + 2 * i], lg_adrb[10 + 2 * i], 8 + i, 8 + i);
            else npass++;
        end
        ntot++;
        if (n_wea !== 4 || n_web !== 4 || n_tl !== 1 || lg_tln[8] !== 1'b0 || n_req !== 1)
            $display("FAIL basic_counts: wea=%0d web=%0d tl=%0d tl8=%b req=%0d want 4 4 1 0 1", n_wea, n_web, n_tl, lg_tln[8], n_req);
        else npass++;
        ntot++;
        if (lg_busy[15] !== 1'b1 || lg_busy[16] !== 1'b0)
            $display("FAIL basic_busy: c15=%b c16=%b want 1 0", lg_busy[15], lg_busy[16]);
        else npass++;
    endtask

    task automatic test_odd_xpos();
        run_job(9'h011, 8'd7, 1'b0, 2, -1, -1);
        ntot++;
        if (lg_xd0[2] !== 1'b1) $display("FAIL odd_xpos_d0: got %b want 1", lg_xd0[2]);
        else npass++;
        for (int i = 0; i < 4; i++) begin
            ntot++;
            if (lg_wea[10 + 2 * i] !== 1'b0 || lg_web[10 + 2 * i] !== 1'b0 ||
                lg_adra[10 + 2 * i] !== 8'(9 + i) || lg_adrb[10 + 2 * i] !== 8'(8 + i))
                $display("FAIL odd_pair%0d: we=%b%b a=%h b=%h want 00 %h %h", i,
                         lg_wea[10 + 2 * i], lg_web[10 + 2 * i], lg_adra[10 + 2 * i], lg_adrb[10 + 2 * i], 9 + i, 8 + i);
            else npass++;
        end
    endtask

    task automatic test_odd_width();
        run_job(9'h020, 8'd4, 1'b0, 2, -1, -1);
        ntot++;
        if (lg_adra[10] !== 8'h10 || lg_adrb[10] !== 8'h10 || lg_adra[12] !== 8'h11 || lg_adrb[12] !== 8'h11 ||
            lg_wea[10] !== 1'b0 || lg_web[12] !== 1'b0)
            $display("FAIL oddw_pairs: a10=%h b10=%h a12=%h b12=%h want 10 10 11 11", lg_adra[10], lg_adrb[10], lg_adra[12], lg_adrb[12]);
        else npass++;
        ntot++;
        if (lg_wea[14] !== 1'b0 || lg_web[14] !== 1'b1 || lg_adra[14] !== 8'h12)
            $display("FAIL oddw_lone: we=%b%b a=%h want 01 12", lg_wea[14], lg_web[14], lg_adra[14]);
        else npass++;
        ntot++;
        if (n_wea !== 3 || n_web !== 2) $display("FAIL oddw_counts: wea=%0d web=%0d want 3 2", n_wea, n_web);
        else npass++;
        ntot++;
        if (lg_wait[11] !== 1'b0 || n_wait !== 1) $display("FAIL oddw_wait: c11=%b n=%0d want 0 1", lg_wait[11], n_wait);
        else npass++;
        ntot++;
        if (lg_busy[13] !== 1'b1 || lg_busy[14] !== 1'b0)
            $display("FAIL oddw_busy: c13=%b c14=%b want 1 0", lg_busy[13], lg_busy[14]);
        else npass++;
    endtask

    task automatic test_hflip();
        int wc [8] = '{18, 20, 22, 24, 34, 36, 38, 40};
        run_job(9'h000, 8'd15, 1'b1, 10, -1, -1);
        ntot++;
        if (lg_tidx[1] !== 5'd1 || lg_req[17] !== 1'b1 || lg_tidx[17] !== 5'd0 || n_req !== 2)
            $display("FAIL hflip_req: tidx1=%0d req17=%b tidx17=%0d nreq=%0d want 1 1 0 2", lg_tidx[1], lg_req[17], lg_tidx[17], n_req);
        else npass++;
        for (int i = 0; i < 8; i++) begin
            ntot++;
            if (lg_sel[13 + i] !== 3'(7 - i) || lg_sel[29 + i] !== 3'(7 - i))
                $display("FAIL hflip_sel%0d: t0=%0d t1=%0d want %0d", i, lg_sel[13 + i], lg_sel[29 + i], 7 - i);
            else npass++;
            ntot++;
            if (lg_wea[wc[i]] !== 1'b0 || lg_web[wc[i]] !== 1'b0 || lg_adra[wc[i]] !== 8'(i) || lg_adrb[wc[i]] !== 8'(i))
                $display("FAIL hflip_we%0d: we=%b%b a=%h b=%h want 00 %h", i, lg_wea[wc[i]], lg_web[wc[i]], lg_adra[wc[i]], lg_adrb[wc[i]], i);
            else npass++;
        end
        for (int c = 21; c <= 28; c++) begin
            ntot++;
            if (lg_sel[c] !== 3'd0) $display("FAIL hflip_hold%0d: sel got %0d want 0", c, lg_sel[c]);
            else npass++;
        end
        ntot++;
        if (n_wea !== 8 || n_web !== 8 || n_tl !== 2 || lg_tln[16] !== 1'b0 || lg_tln[32] !== 1'b0)
            $display("FAIL hflip_counts: wea=%0d web=%0d tl=%0d tl16=%b tl32=%b want 8 8 2 0 0", n_wea, n_web, n_tl, lg_tln[16], lg_tln[32]);
        else npass++;
        ntot++;
        if (lg_busy[39] !== 1'b1 || lg_busy[40] !== 1'b0)
            $display("FAIL hflip_busy: c39=%b c40=%b want 1 0", lg_busy[39], lg_busy[40]);
        else npass++;
    endtask

    task automatic test_wrap();
        run_job(9'h1FE, 8'd3, 1'b0, 2, -1, -1);
        ntot++;
        if (lg_wea[10] !== 1'b0 || lg_adra[10] !== 8'hFF || lg_adrb[10] !== 8'hFF)
            $display("FAIL wrap_first: we_a=%b a=%h b=%h want 0 ff ff", lg_wea[10], lg_adra[10], lg_adrb[10]);
        else npass++;
        ntot++;
        if (lg_web[12] !== 1'b0 || lg_adra[12] !== 8'h00 || lg_adrb[12] !== 8'h00 || n_wea !== 2)
            $display("FAIL wrap_second: we_b=%b a=%h b=%h nwea=%0d want 0 00 00 2", lg_web[12], lg_adra[12], lg_adrb[12], n_wea);
        else npass++;
    endtask

    task automatic test_mid_reset();
        int nwe;
        run_job(9'h000, 8'd15, 1'b0, 2, 7, -1);
        ntot++;
        if ({lg_busy[8], lg_req[8], lg_wr[8], lg_tln[8], lg_col[8], lg_wait[8], lg_wea[8], lg_web[8]} !== 8'b0001_1111 ||
            lg_sel[8] !== 3'd0 || lg_tidx[8] !== 5'd0 || lg_adra[8] !== 8'd0 || lg_adrb[8] !== 8'd0)
            $display("FAIL midrst_outputs: ctrl=%b sel=%0d tidx=%0d a=%h b=%h want 00011111 0 0 00 00",
                     {lg_busy[8], lg_req[8], lg_wr[8], lg_tln[8], lg_col[8], lg_wait[8], lg_wea[8], lg_web[8]},
                     lg_sel[8], lg_tidx[8], lg_adra[8], lg_adrb[8]);
        else npass++;
        nwe = 0;
        for (int c = 8; c <= last_k; c++) if (!lg_wea[c] || !lg_web[c]) nwe++;
        ntot++;
        if (nwe !== 0) $display("FAIL midrst_no_we: got %0d write cycles want 0", nwe);
        else npass++;
        run_job(9'h040, 8'd1, 1'b0, 2, -1, -1);
        ntot++;
        if (lg_req[1] !== 1'b1 || lg_wea[10] !== 1'b0 || lg_adra[10] !== 8'h20 || lg_adrb[10] !== 8'h20)
            $display("FAIL midrst_restart: req=%b we_a=%b a=%h b=%h want 1 0 20 20", lg_req[1], lg_wea[10], lg_adra[10], lg_adrb[10]);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_basic();
        test_odd_xpos();
        test_odd_width();
        test_hflip();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
